uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Wishbone-classic slave that buffers bytes in a small FIFO and sends them
// out as 8N1 UART frames (start bit 0, eight data bits LSB first, stop bit 1).
//
// Register map (adr_i):
//   0 TXDATA  write: push byte into the TX FIFO (wait-states while full)
//             read : returns 0, no side effects
//   1 STATUS  read : {count[4:0] saturated at 31, busy, full, empty}
//             write: acknowledged and ignored
//
// Ports:
//   clk_i    single clock, everything on its rising edge
//   rst_i    asynchronous active-high reset (aborts any frame in flight)
//   cyc_i    Wishbone cycle
//   stb_i    Wishbone strobe
//   we_i     Wishbone write enable
//   adr_i    register select
//   dat_i    write data
//   dat_o    read data (registered, valid with ack_o)
//   ack_o    single-cycle acknowledge
//   uart_tx  serial output, idle high, driven straight from a flop
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (4 or more)
//   FIFO_DEPTH    FIFO entries, power of two from 2 to 256
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic       adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // $clog2(N) bits always hold N-1, the last baud count value.
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  // Transmitter states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [BW-1:0] baud_reg;
  logic [BW-1:0] baud_next;
  logic [2:0]    bit_idx_reg;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          tx_next;

  logic          ack_reg;
  logic [7:0]    dat_reg;

  // ---------------------------------------------------------------------------
  // Decoded flags
  // ---------------------------------------------------------------------------
  logic       empty;
  logic       full;
  logic       busy;
  logic       baud_last;
  logic       pop;
  logic       push;
  logic       req;
  logic       wr_data_req;
  logic       accept;
  logic [8:0] count_ext;
  logic [4:0] count_sat;
  logic [7:0] status_word;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == DEPTH_C);
  assign busy      = (state_reg != IDLE);
  assign baud_last = (baud_reg == BAUD_LAST);

  // The transmitter takes the head either when it sits idle or at the very
  // end of a stop bit, which is what makes consecutive frames seamless.
  assign pop = !empty && ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));

  // A request is only seen while ack is low, so each handshake acks once.
  assign req         = cyc_i && stb_i && !ack_reg;
  assign wr_data_req = req && we_i && !adr_i;

  // A full FIFO still accepts a byte in the cycle the transmitter pops,
  // otherwise the write is held in wait states.
  assign push   = wr_data_req && (!full || pop);
  assign accept = push || (req && !(we_i && !adr_i));

  assign count_ext   = 9'(count_reg);
  assign count_sat   = (count_ext > 9'd31) ? 5'd31 : count_ext[4:0];
  assign status_word = {count_sat, busy, full, empty};

  // ---------------------------------------------------------------------------
  // Bus side: ack and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= 8'h00;
    end else begin
      ack_reg <= accept;
      if (accept) begin
        dat_reg <= (!we_i && adr_i) ? status_word : 8'h00;
      end
    end
  end

  assign ack_o = ack_reg;
  assign dat_o = dat_reg;

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Memory array and head read. When full with push and pop together the
  // pointers coincide; the non-blocking read returns the old head, which is
  // the byte that is leaving.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= dat_i;
    end
    if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    case (state_reg)
      IDLE: begin
        baud_next    = '0;
        bit_idx_next = '0;
        if (!empty) begin
          state_next = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx_reg == 3'd7) begin
            bit_idx_next = '0;
            state_next   = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next  = '0;
          state_next = empty ? IDLE : START;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        baud_next    = '0;
        bit_idx_next = '0;
      end
    endcase
  end

  // Line level follows the current state one cycle later; every bit gets the
  // same one-cycle shift, so bit widths stay exactly CLKS_PER_BIT.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[bit_idx_reg];
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  assign uart_tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4. A reference
// model keeps a list of accepted bytes with the time each frame starts on the
// line; frame start = max(previous start + 10 bit periods, push edge + 2).
// From that list it derives FIFO occupancy, busy, the expected ack and the
// expected line level for every cycle. Directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc = 1'b0;
  logic       stb = 1'b0;
  logic       we  = 1'b0;
  logic       adr = 1'b0;
  logic [7:0] dat_w = 8'h00;
  logic [7:0] dat_r;
  logic       ack;
  logic       tx;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cyc_i  (cyc),
    .stb_i  (stb),
    .we_i   (we),
    .adr_i  (adr),
    .dat_i  (dat_w),
    .dat_o  (dat_r),
    .ack_o  (ack),
    .uart_tx(tx)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int         push_e;
    int         start;
    logic [7:0] b;
  } frame_t;

  frame_t frames[$];
  int     edge_n     = 0;
  int     last_start = -100000;
  logic   m_ack      = 1'b0;
  logic   m_rd       = 1'b0;
  logic [7:0] m_dat  = 8'h00;

  // Bytes held in the FIFO after edge m (popped one edge before the frame).
  function automatic int count_after(int m);
    int c = 0;
    foreach (frames[i]) begin
      if (frames[i].push_e <= m) c++;
      if (frames[i].start - 1 <= m) c--;
    end
    return c;
  endfunction

  // Transmitter busy from the pop edge until one edge before the line ends.
  function automatic logic busy_after(int m);
    foreach (frames[i]) begin
      if (m >= frames[i].start - 1 && m <= frames[i].start + FRAME - 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic pop_at(int n);
    foreach (frames[i]) begin
      if (frames[i].start - 1 == n) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic tx_at(int n);
    int k;
    logic [7:0] b;
    foreach (frames[i]) begin
      if (n >= frames[i].start && n < frames[i].start + FRAME) begin
        k = (n - frames[i].start) / CPB;
        b = frames[i].b;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
      end
    end
    return 1'b1;
  endfunction

  // Single compare process: predicts each edge from pre-edge inputs, then
  // checks the DUT just after the edge.
  always @(posedge clk) begin
    int         cnt;
    int         st;
    logic       req;
    logic       bsy;
    logic [4:0] sat;
    frame_t     f;
    edge_n++;
    if (rst) begin
      frames.delete();
      last_start = -100000;
      m_ack      = 1'b0;
      m_rd       = 1'b0;
    end else begin
      req  = cyc && stb && !m_ack;
      cnt  = count_after(edge_n - 1);
      bsy  = busy_after(edge_n - 1);
      m_rd = 1'b0;
      if (!req) begin
        m_ack = 1'b0;
      end else if (we && !adr) begin
        if (cnt < DEPTH || pop_at(edge_n)) begin
          st = (last_start + FRAME > edge_n + 2) ? last_start + FRAME : edge_n + 2;
          f.push_e = edge_n;
          f.start  = st;
          f.b      = dat_w;
          frames.push_back(f);
          last_start = st;
          m_ack = 1'b1;
        end else begin
          m_ack = 1'b0;
        end
      end else begin
        m_ack = 1'b1;
        if (!we) begin
          m_rd  = 1'b1;
          sat   = (cnt > 31) ? 5'd31 : 5'(cnt);
          m_dat = adr ? {sat, bsy, (cnt == DEPTH), (cnt == 0)} : 8'h00;
        end
      end
      while (frames.size() > 0 && frames[0].start + FRAME + 4 < edge_n) begin
        void'(frames.pop_front());
      end
    end
    #1;
    total++;
    if (ack !== m_ack) begin
      bad++;
      $display("FAIL model_ack @edge %0d: got %b expected %b", edge_n, ack, m_ack);
    end
    total++;
    if (tx !== tx_at(edge_n)) begin
      bad++;
      $display("FAIL model_tx @edge %0d: got %b expected %b", edge_n, tx, tx_at(edge_n));
    end
    if (m_ack && m_rd) begin
      total++;
      if (dat_r !== m_dat) begin
        bad++;
        $display("FAIL model_dat @edge %0d: got %02h expected %02h", edge_n, dat_r, m_dat);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic a, input logic [7:0] d,
                         output logic [7:0] rd, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    rd    = 8'h00;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    while (!got && waits < 1000) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        rd  = dat_r;
      end else begin
        waits++;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL wb_timeout: no ack after %0d cycles, expected an ack", waits);
    end else begin
      $display("xfer we=%0b adr=%0b wdata=%02h rdata=%02h waits=%0d", w, a, d, rd, waits);
    end
  endtask

  // Drives a TXDATA write for n edges then withdraws it; returns acks seen.
  task automatic wb_abort(input logic [7:0] d, input int n, output int acks);
    acks = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 1'b0; dat_w = d;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("abort wdata=%02h cycles=%0d acks=%0d", d, n, acks);
  endtask

  task automatic read_status(input string name, input int exp);
    logic [7:0] rd;
    int         w;
    wb_xfer(1'b0, 1'b1, 8'h00, rd, w);
    chk(name, rd, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] rd;
    logic [9:0] pat;
    int         w;
    int         acks;
    int         e;
    int         op;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ack", ack, 0);
    chk("reset_dat", dat_r, 0);
    rst = 1'b0;

    // 0x41 frame, bits in line order: 0,1,0,0,0,0,0,1,0,1
    pat = 10'b1010000010;
    wb_xfer(1'b1, 1'b0, 8'h41, rd, w);
    chk("ack_no_wait_0x41", w, 0);
    for (int i = 1; i <= 46; i++) begin
      @(posedge clk);
      #1;
      if (i < 2 || i - 2 >= 40) e = 1;
      else e = int'(pat[(i - 2) / 4]);
      chk("tx_0x41", tx, e);
    end
    read_status("status_idle_after_0x41", 8'h01);

    // Back-to-back frames
    wb_xfer(1'b1, 1'b0, 8'h55, rd, w);
    wb_xfer(1'b1, 1'b0, 8'hAA, rd, w);
    repeat (100) @(negedge clk);
    read_status("status_after_55_aa", 8'h01);

    // TXDATA read returns 0, STATUS write ignored
    wb_xfer(1'b0, 1'b0, 8'h00, rd, w);
    chk("txdata_read_zero", rd, 0);
    wb_xfer(1'b1, 1'b1, 8'hFF, rd, w);
    read_status("status_after_status_write", 8'h01);

    // Two bytes: one in the shifter, one buffered
    wb_xfer(1'b1, 1'b0, 8'h3C, rd, w);
    wb_xfer(1'b1, 1'b0, 8'hC3, rd, w);
    read_status("status_two_bytes", 8'h0C);
    repeat (100) @(negedge clk);
    read_status("status_two_drained", 8'h01);

    // Fill, withdrawn write on full, stalled sixth write, drain
    for (int i = 0; i < 5; i++) begin
      wb_xfer(1'b1, 1'b0, 8'(8'h10 + i), rd, w);
    end
    read_status("status_full", 8'h26);
    wb_abort(8'hEE, 5, acks);
    chk("abort_no_ack", acks, 0);
    read_status("status_full_after_abort", 8'h26);
    wb_xfer(1'b1, 1'b0, 8'h15, rd, w);
    chk("full_write_waited", (w > 0) ? 1 : 0, 1);
    repeat (6 * FRAME + 20) @(negedge clk);
    read_status("status_fill_drained", 8'h01);

    // Reset during data bit 3 of 0xA5 (bit3 = 0)
    wb_xfer(1'b1, 1'b0, 8'hA5, rd, w);
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk("tx_bit3_low", tx, 0);
    rst = 1'b1;
    #1;
    chk("tx_high_on_async_reset", tx, 1);
    chk("ack_low_on_reset", ack, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    read_status("status_after_reset", 8'h01);
    repeat (60) @(negedge clk);
    chk("tx_idle_after_reset", tx, 1);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      op = $urandom_range(0, 99);
      if (op < 60) begin
        wb_xfer(1'b1, 1'b0, 8'($urandom_range(0, 255)), rd, w);
      end else if (op < 75) begin
        wb_xfer(1'b0, 1'b1, 8'h00, rd, w);
      end else if (op < 85) begin
        wb_xfer(1'b0, 1'b0, 8'h00, rd, w);
      end else if (op < 93) begin
        wb_xfer(1'b1, 1'b1, 8'($urandom_range(0, 255)), rd, w);
      end else begin
        wb_abort(8'($urandom_range(0, 255)), $urandom_range(1, 3), acks);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(20, 80)) @(negedge clk);
    end
    repeat (DEPTH * FRAME + 2 * FRAME) @(negedge clk);
    read_status("status_final", 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
